add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter FLOAT_DATA_WIDTH, default 32, IEEE-754 single operand/result width.
REQ-002 SHALL have parameter ADD_LATENCY, default 5, adder pipeline depth in enabled clock cycles.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clk_en  input  1  global stall; low freezes all state.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1 each  requester N presents an operand pair.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  FLOAT_DATA_WIDTH each  operands.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1 each  grant; transfer when valid && ready.
REQ-009 SHALL have ports rsp0_valid / rsp1_valid  output  1 each  one-cycle result pulse.
REQ-010 SHALL have ports rsp0_data / rsp1_data  output  FLOAT_DATA_WIDTH each  sum for that requester.
REQ-011 SHALL have port flush  input  1  synchronous discard of all in-flight operations.
REQ-012 SHALL have ports add_clk_en (1), add_aclr (1), add_dataa, add_datab (FLOAT_DATA_WIDTH)  outputs  drive the shared adder.
REQ-013 SHALL have port add_result  input  FLOAT_DATA_WIDTH  shared adder output.
REQ-014 SHALL have port busy  output  1  high while any operation is in flight.

Function
REQ-015 SHALL combinationally assert at most one reqN_ready per cycle, and only when clk_en is high and flush is low.
REQ-016 SHALL, with a single valid requester, grant it; with both valid, grant the requester not granted on the last accepted transfer (round-robin; requester 0 after reset).
REQ-017 SHALL drive add_dataa/add_datab combinationally with the granted requester's a/b, holding the last driven values when nothing is granted.
REQ-018 SHALL drive add_clk_en = clk_en and add_aclr = ~rst.
REQ-019 SHALL shift a tag pipeline (valid bit + requester id, depth ADD_LATENCY) on every edge with clk_en high; stage 0 loads the accepted transfer or an invalid tag.
REQ-020 SHALL, on an enabled edge where the last tag stage is valid, register add_result into rspN_data and pulse rspN_valid for exactly one cycle for the tagged requester; accept-to-rsp_valid latency is ADD_LATENCY+1 cycles absent stalls.
REQ-021 SHALL clear both rspN_valid on every edge not producing a result, including stalled edges; rspN_data SHALL hold between results.
REQ-022 SHALL sustain one accepted transfer per enabled cycle, with up to ADD_LATENCY operations in flight.
REQ-023 SHALL keep an in-flight counter (0..ADD_LATENCY+1): increment on accept, decrement on result; simultaneous accept and result leave it unchanged; busy = counter != 0.
REQ-024 SHALL, with clk_en low, hold tag pipeline, counter, round-robin pointer and rsp data unchanged.
REQ-025 SHALL, on an enabled edge with flush high, invalidate all tag stages, zero the counter and suppress any rsp_valid due on that edge; grants are blocked that cycle.
REQ-026 SHALL stall nothing downstream: requesters must accept rsp pulses unconditionally.

Reset
REQ-027 SHALL, while rst is low, force reqN_ready=0, rspN_valid=0, rspN_data=0, busy=0, tags invalid, counter 0, round-robin pointer to requester 0, add_dataa/add_datab=0 (muxed hold registers).
REQ-028 SHALL discard operations in flight when reset is asserted; no rsp_valid pulse occurs for them after release.

Structure
REQ-029 SHALL take FLOAT_DATA_WIDTH, ADD_LATENCY and requester-id encoding (REQ_ID_0=0, REQ_ID_1=1) from the shared adder package.
REQ-030 SHALL instantiate one sub-module, tag_pipe, implementing the enabled, flushable valid+id delay line of depth ADD_LATENCY.

Verification (bench uses a behavioural adder model of latency ADD_LATENCY)
REQ-031 Single: req0 1.0 (0x3F800000) + 2.0 (0x40000000) accepted at cycle 0 -> rsp0_valid at cycle 6, rsp0_data 0x40400000, busy low at cycle 7.
REQ-032 Contention: both valid continuously, req0 4.0+0.5, req1 1.0+2.0 -> grants alternate 0,1,0,1; rsp pulses alternate; rsp0 0x40900000, rsp1 0x40400000.
REQ-033 Stall: clk_en low 3 cycles after accept -> rsp0_valid delayed exactly 3 cycles, data unchanged; no ready during stall.
REQ-034 Flush: 3 ops in flight, flush pulsed -> no rsp pulses for them, busy low next cycle; a new op after flush returns its correct sum.
REQ-035 Reset mid-operation: rst low with 4 ops in flight -> all outputs zero; after release no stale rsp_valid, first grant goes to requester 0.
REQ-036 Back-to-back: 5 consecutive accepts from req1 -> counter reaches 5, five consecutive rsp1_valid pulses in order.

Source files
------------

// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the two-requester floating-point adder arbiter:
// default widths, adder depth and the requester-id encoding.
package add_arbiter_pkg;

  localparam int FLOAT_DATA_WIDTH = 32;
  localparam int ADD_LATENCY      = 5;

  typedef enum logic {
    REQ_ID_0 = 1'b0,
    REQ_ID_1 = 1'b1
  } req_id_e;

  // One slot of the delay line that travels alongside the adder pipeline.
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

endpackage

// File: rtl/add_arbiter_if.sv
// Request/response bundle between the two requesters and the arbiter.
// The master side belongs to the requesters; the slave side belongs to the arbiter.
interface add_arbiter_if
  import add_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = FLOAT_DATA_WIDTH
) ();

  logic                  req0_valid;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic                  req0_ready;
  logic                  req1_ready;
  logic                  rsp0_valid;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp0_data;
  logic [DATA_WIDTH-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

endinterface

// File: rtl/add_arbiter_tag_pipe.sv
// Valid + requester-id delay line that mirrors the shared adder pipeline.
// It advances only on enabled edges, and a flush on an enabled edge empties it.
module add_arbiter_tag_pipe
  import add_arbiter_pkg::*;
#(
  parameter int DEPTH = ADD_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic flush,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stages_q [DEPTH];

  // NOTE: this array holds control state, so every entry must come out of reset
  // invalid. Unlike a data RAM it is cheap flops and must not be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stages_q[i] <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments make every stage shift on the same
      // pre-edge values, so this loop models a true shift register.
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) stages_q[i] <= '0;
      end else begin
        stages_q[0] <= tag_in;
        for (int i = 1; i < DEPTH; i++) stages_q[i] <= stages_q[i-1];
      end
    end
  end

  assign tag_out = stages_q[DEPTH-1];

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter that shares one pipelined FP adder between two requesters.
// Each result is routed back to its requester by tagging the operation as it enters the adder.
module add_arbiter #(
  parameter int FLOAT_DATA_WIDTH = add_arbiter_pkg::FLOAT_DATA_WIDTH,
  parameter int ADD_LATENCY      = add_arbiter_pkg::ADD_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        flush,
  add_arbiter_if.slave                bus,
  output logic                        add_clk_en,
  output logic                        add_aclr,
  output logic [FLOAT_DATA_WIDTH-1:0] add_dataa,
  output logic [FLOAT_DATA_WIDTH-1:0] add_datab,
  input  logic [FLOAT_DATA_WIDTH-1:0] add_result,
  output logic                        busy
);

  import add_arbiter_pkg::*;

  localparam int CNT_W = $clog2(ADD_LATENCY + 2);

  logic                        grant_en;
  logic                        gnt0;
  logic                        gnt1;
  logic                        accept;
  logic                        result;
  req_id_e                     gnt_id;
  req_id_e                     rr_ptr_q;
  logic [FLOAT_DATA_WIDTH-1:0] sel_a;
  logic [FLOAT_DATA_WIDTH-1:0] sel_b;
  logic [FLOAT_DATA_WIDTH-1:0] hold_a_q;
  logic [FLOAT_DATA_WIDTH-1:0] hold_b_q;
  logic                        rsp0_valid_q;
  logic                        rsp1_valid_q;
  logic [FLOAT_DATA_WIDTH-1:0] rsp0_data_q;
  logic [FLOAT_DATA_WIDTH-1:0] rsp1_data_q;
  logic [CNT_W-1:0]            cnt_q;
  tag_t                        tag_in;
  tag_t                        tag_out;

  // Grants are blocked during reset, during a stall and on a flush cycle.
  assign grant_en = rst & clk_en & ~flush;

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that leaves
    // one unassigned would infer a latch.
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    sel_a = hold_a_q;
    sel_b = hold_b_q;
    if (grant_en) begin
      if (bus.req0_valid && (!bus.req1_valid || rr_ptr_q == REQ_ID_0)) gnt0 = 1'b1;
      else if (bus.req1_valid)                                        gnt1 = 1'b1;
    end
    if (gnt0) begin
      sel_a = bus.req0_a;
      sel_b = bus.req0_b;
    end else if (gnt1) begin
      sel_a = bus.req1_a;
      sel_b = bus.req1_b;
    end
  end

  assign accept         = gnt0 | gnt1;
  assign gnt_id         = gnt1 ? REQ_ID_1 : REQ_ID_0;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign add_dataa      = sel_a;
  assign add_datab      = sel_b;
  assign add_clk_en     = clk_en;
  assign add_aclr       = ~rst;

  // The pointer names the requester that wins the next contended cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= REQ_ID_0;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else if (accept) begin
      rr_ptr_q <= gnt1 ? REQ_ID_0 : REQ_ID_1;
      hold_a_q <= sel_a;
      hold_b_q <= sel_b;
    end
  end

  assign tag_in.valid = accept;
  assign tag_in.id    = gnt_id;

  add_arbiter_tag_pipe #(
    .DEPTH (ADD_LATENCY)
  ) tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .en      (clk_en),
    .flush   (flush),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // A result leaves the adder on this edge unless a flush discards it.
  assign result = tag_out.valid & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      if (clk_en && result) begin
        if (tag_out.id == REQ_ID_1) begin
          rsp1_valid_q <= 1'b1;
          rsp1_data_q  <= add_result;
        end else begin
          rsp0_valid_q <= 1'b1;
          rsp0_data_q  <= add_result;
        end
      end
    end
  end

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clk_en) begin
      if (flush) begin
        cnt_q <= '0;
      end else begin
        case ({accept, result})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: a behavioural adder of depth ADD_LATENCY with
// hand-computed sums, and a negedge monitor that timestamps every grant and response.
module tb_add_arbiter;
  import add_arbiter_pkg::*;

  localparam int W = FLOAT_DATA_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         clk_en;
  logic         flush;
  logic         add_clk_en;
  logic         add_aclr;
  logic [W-1:0] add_dataa;
  logic [W-1:0] add_datab;
  logic [W-1:0] add_result;
  logic         busy;

  add_arbiter_if #(.DATA_WIDTH(W)) bus ();

  add_arbiter #(
    .FLOAT_DATA_WIDTH (W),
    .ADD_LATENCY      (ADD_LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .flush      (flush),
    .bus        (bus),
    .add_clk_en (add_clk_en),
    .add_aclr   (add_aclr),
    .add_dataa  (add_dataa),
    .add_datab  (add_datab),
    .add_result (add_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Operand encodings and their hand-computed sums.
  localparam logic [W-1:0] F0_5 = 32'h3F00_0000;
  localparam logic [W-1:0] F1   = 32'h3F80_0000;
  localparam logic [W-1:0] F2   = 32'h4000_0000;
  localparam logic [W-1:0] F3   = 32'h4040_0000;
  localparam logic [W-1:0] F4   = 32'h4080_0000;
  localparam logic [W-1:0] F4_5 = 32'h4090_0000;
  localparam logic [W-1:0] F6   = 32'h40C0_0000;
  localparam logic [W-1:0] F8   = 32'h4100_0000;

  function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
    case ({a, b})
      {F1, F2}:   return F3;
      {F4, F0_5}: return F4_5;
      {F1, F1}:   return F2;
      {F2, F2}:   return F4;
      {F2, F4}:   return F6;
      {F4, F4}:   return F8;
      default:    return 32'hFFFF_FFFF;
    endcase
  endfunction

  logic [W-1:0] add_pipe_q [ADD_LATENCY];

  always @(posedge clk or posedge add_aclr) begin
    if (add_aclr) begin
      for (int i = 0; i < ADD_LATENCY; i++) add_pipe_q[i] <= '0;
    end else if (add_clk_en) begin
      add_pipe_q[0] <= fadd(add_dataa, add_datab);
      for (int i = 1; i < ADD_LATENCY; i++) add_pipe_q[i] <= add_pipe_q[i-1];
    end
  end

  assign add_result = add_pipe_q[ADD_LATENCY-1];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  int           g0_q[$];
  int           g1_q[$];
  int           r0_c[$];
  int           r1_c[$];
  logic [W-1:0] r0_d[$];
  logic [W-1:0] r1_d[$];

  always @(negedge clk) begin
    check("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
    if (bus.req0_ready) g0_q.push_back(cyc);
    if (bus.req1_ready) g1_q.push_back(cyc);
    if (bus.rsp0_valid) begin r0_c.push_back(cyc); r0_d.push_back(bus.rsp0_data); end
    if (bus.rsp1_valid) begin r1_c.push_back(cyc); r1_d.push_back(bus.rsp1_data); end
  end

  task automatic clear_mon();
    g0_q.delete(); g1_q.delete();
    r0_c.delete(); r1_c.delete();
    r0_d.delete(); r1_d.delete();
  endtask

  task automatic check_stamps(input string tag, input int got[$], input int exp[$]);
    check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic check_data(input string tag, input logic [W-1:0] got[$], input logic [W-1:0] exp[$]);
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    clk_en = 1'b1;
    flush  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  int t0;
  logic [W-1:0] b2b_a [5] = '{F1, F1, F2, F2, F4};
  logic [W-1:0] b2b_b [5] = '{F2, F1, F2, F4, F4};

  initial begin
    idle();
    rst = 1'b0;
    #1;
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("rst_rsp1_data",  bus.rsp1_data,        32'd0);
    check("rst_add_aclr",   32'(add_aclr),        32'd1);
    do_reset();

    // Single transfer from requester 0.
    clear_mon();
    t0 = cyc;
    drive(1'b1, F1, F2, 1'b0, '0, '0);
    #1;
    check("single_dataa", add_dataa, F1);
    check("single_datab", add_datab, F2);
    step();
    idle();
    check("single_busy_c1", 32'(busy), 32'd1);
    repeat (5) step();
    check("single_hold_dataa", add_dataa, F1);
    step();
    check("single_busy_c7", 32'(busy), 32'd0);
    step();
    check_stamps("single_g0", g0_q, '{t0});
    check_stamps("single_r0", r0_c, '{t0 + 6});
    check_data("single_r0_data", r0_d, '{F3});
    check_stamps("single_r1", r1_c, '{});

    // Contention: both requesters valid for four cycles.
    do_reset();
    clear_mon();
    t0 = cyc;
    drive(1'b1, F4, F0_5, 1'b1, F1, F2);
    repeat (4) step();
    idle();
    repeat (8) step();
    check_stamps("cont_g0", g0_q, '{t0, t0 + 2});
    check_stamps("cont_g1", g1_q, '{t0 + 1, t0 + 3});
    check_stamps("cont_r0", r0_c, '{t0 + 6, t0 + 8});
    check_stamps("cont_r1", r1_c, '{t0 + 7, t0 + 9});
    check_data("cont_r0_data", r0_d, '{F4_5, F4_5});
    check_data("cont_r1_data", r1_d, '{F3, F3});

    // Stall: clk_en low for three cycles while the operation is in flight.
    do_reset();
    clear_mon();
    t0 = cyc;
    drive(1'b1, F1, F2, 1'b0, '0, '0);
    step();
    idle();
    step();
    clk_en = 1'b0;
    drive(1'b0, '0, '0, 1'b1, F4, F0_5);
    #1;
    check("stall_add_clk_en", 32'(add_clk_en), 32'd0);
    check("stall_busy",       32'(busy),       32'd1);
    repeat (3) step();
    idle();
    repeat (6) step();
    check_stamps("stall_g0", g0_q, '{t0});
    check_stamps("stall_g1", g1_q, '{});
    check_stamps("stall_r0", r0_c, '{t0 + 9});
    check_data("stall_r0_data", r0_d, '{F3});

    // Flush with three operations in flight, then a fresh operation.
    do_reset();
    clear_mon();
    t0 = cyc;
    drive(1'b1, F1, F2, 1'b0, '0, '0);
    step();
    drive(1'b0, '0, '0, 1'b1, F4, F0_5);
    step();
    drive(1'b1, F1, F2, 1'b0, '0, '0);
    step();
    idle();
    step();
    flush = 1'b1;
    drive(1'b1, F4, F0_5, 1'b0, '0, '0);
    #1;
    check("flush_busy_before", 32'(busy), 32'd1);
    step();
    flush = 1'b0;
    check("flush_busy_after", 32'(busy), 32'd0);
    step();
    idle();
    repeat (8) step();
    check_stamps("flush_g0", g0_q, '{t0, t0 + 2, t0 + 5});
    check_stamps("flush_g1", g1_q, '{t0 + 1});
    check_stamps("flush_r0", r0_c, '{t0 + 11});
    check_stamps("flush_r1", r1_c, '{});
    check_data("flush_r0_data", r0_d, '{F4_5});

    // Reset with four operations in flight; the pointer currently favours requester 1.
    clear_mon();
    t0 = cyc;
    drive(1'b1, F4, F0_5, 1'b1, F1, F2);
    repeat (4) step();
    rst = 1'b0;
    #1;
    check("mrst_ready0",     32'(bus.req0_ready), 32'd0);
    check("mrst_ready1",     32'(bus.req1_ready), 32'd0);
    check("mrst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("mrst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check("mrst_rsp0_data",  bus.rsp0_data,        32'd0);
    check("mrst_busy",       32'(busy),           32'd0);
    check("mrst_dataa",      add_dataa,            32'd0);
    check("mrst_datab",      add_datab,            32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    idle();
    repeat (8) step();
    check_stamps("mrst_g0", g0_q, '{t0 + 1, t0 + 3, t0 + 6});
    check_stamps("mrst_g1", g1_q, '{t0, t0 + 2});
    check_stamps("mrst_r0", r0_c, '{t0 + 12});
    check_stamps("mrst_r1", r1_c, '{});
    check_data("mrst_r0_data", r0_d, '{F4_5});

    // Back-to-back: five consecutive transfers from requester 1.
    clear_mon();
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, 1'b1, b2b_a[i], b2b_b[i]);
      step();
    end
    idle();
    check("b2b_cnt",  32'(dut.cnt_q), 32'd5);
    check("b2b_busy", 32'(busy),      32'd1);
    repeat (10) step();
    check_stamps("b2b_g1", g1_q, '{t0, t0 + 1, t0 + 2, t0 + 3, t0 + 4});
    check_stamps("b2b_r1", r1_c, '{t0 + 6, t0 + 7, t0 + 8, t0 + 9, t0 + 10});
    check_data("b2b_r1_data", r1_d, '{F3, F2, F4, F6, F8});
    check_stamps("b2b_r0", r0_c, '{});
    check("b2b_busy_end", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
